// File: rtl/bbm_driver_pkg.sv
// Shared types and defaults for the N-channel break-before-make gate-drive sequencer.
package bbm_driver_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_DEAD  = 2'd1,
    ST_HS_ON = 2'd2,
    ST_LS_ON = 2'd3
  } bbm_state_t;

  localparam int DTW_DEF  = 6;
  localparam int FILT_DEF = 2;

endpackage

// File: rtl/bbm_channel.sv
// One break-before-make channel: state machine, dead-time down-counter and optional
// command glitch filter (enabled by BBM_DRIVER_NCH_GLITCH_FILTER_EN).
module bbm_channel
  import bbm_driver_pkg::*;
#(
  parameter int DTW  = DTW_DEF,
  parameter int FILT = FILT_DEF
) (
  input  logic           CELCLK,
  input  logic           CELRST,
  input  logic           en,
  input  logic           c,
  input  logic [DTW-1:0] dt,
  input  logic           force_off,
  output logic           hs,
  output logic           ls
);

  bbm_state_t     state_reg, state_next;
  logic [DTW-1:0] cnt_reg, cnt_next;
  logic           c_eff;

`ifdef BBM_DRIVER_NCH_GLITCH_FILTER_EN
  // The accepted command only moves once FILT consecutive samples agree.
  logic [FILT-1:0] hist_reg;
  logic            c_filt_reg;

  always_ff @(posedge CELCLK) begin
    if (CELRST) begin
      hist_reg   <= '0;
      c_filt_reg <= 1'b0;
    end else begin
      hist_reg <= (hist_reg << 1) | FILT'(c);
      if (&hist_reg)
        c_filt_reg <= 1'b1;
      else if (~|hist_reg)
        c_filt_reg <= 1'b0;
    end
  end

  assign c_eff = c_filt_reg;
`else
  logic unused_filt_cfg;
  assign unused_filt_cfg = (FILT > 0);
  assign c_eff = c;
`endif

  always_ff @(posedge CELCLK) begin
    if (CELRST) begin
      state_reg <= ST_OFF;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Shutdown beats every other transition; the dead-time count is thrown away.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (force_off || !en) begin
      state_next = ST_OFF;
      cnt_next   = '0;
    end else begin
      unique case (state_reg)
        ST_OFF: begin
          state_next = ST_DEAD;
          cnt_next   = dt;
        end
        ST_HS_ON: begin
          if (!c_eff) begin
            state_next = ST_DEAD;
            cnt_next   = dt;
          end
        end
        ST_LS_ON: begin
          if (c_eff) begin
            state_next = ST_DEAD;
            cnt_next   = dt;
          end
        end
        ST_DEAD: begin
          // Target side is chosen at exit, so reversals during dead time are absorbed.
          if (cnt_reg != '0)
            cnt_next = cnt_reg - 1'b1;
          else
            state_next = c_eff ? ST_HS_ON : ST_LS_ON;
        end
        default: begin
          state_next = ST_OFF;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    hs = 1'b0;
    ls = 1'b0;
    if (state_reg == ST_HS_ON) hs = 1'b1;
    if (state_reg == ST_LS_ON) ls = 1'b1;
  end

endmodule

// File: rtl/bbm_driver_nch.sv
// N-channel break-before-make gate-drive sequencer: owns the fault latch and command
// polarity; optional glitch filter per channel via BBM_DRIVER_NCH_GLITCH_FILTER_EN.
module bbm_driver_nch
  import bbm_driver_pkg::*;
#(
  parameter int             NCH      = 1,
  parameter int             DTW      = DTW_DEF,
  parameter logic [NCH-1:0] INV_MASK = '0,
  parameter int             FILT     = FILT_DEF
) (
  input  logic           CELCLK,
  input  logic           CELRST,
  input  logic [NCH-1:0] en,
  input  logic [NCH-1:0] i,
  input  logic [DTW-1:0] dt,
  input  logic           fault,
  input  logic           fault_clr,
  output logic [NCH-1:0] hs,
  output logic [NCH-1:0] ls,
  output logic           fault_lat
);

  logic           fault_lat_reg, fault_lat_next;
  logic           force_off;
  logic [NCH-1:0] c;

  // A fault raised in the same cycle as a clear keeps the latch set.
  always_comb begin
    fault_lat_next = fault_lat_reg;
    if (fault)
      fault_lat_next = 1'b1;
    else if (fault_clr)
      fault_lat_next = 1'b0;
  end

  always_ff @(posedge CELCLK) begin
    if (CELRST)
      fault_lat_reg <= 1'b0;
    else
      fault_lat_reg <= fault_lat_next;
  end

  assign fault_lat = fault_lat_reg;
  assign force_off = fault_lat_reg | fault;
  assign c         = i ^ INV_MASK;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      bbm_channel #(
        .DTW  (DTW),
        .FILT (FILT)
      ) u_ch (
        .CELCLK    (CELCLK),
        .CELRST    (CELRST),
        .en        (en[gi]),
        .c         (c[gi]),
        .dt        (dt),
        .force_off (force_off),
        .hs        (hs[gi]),
        .ls        (ls[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_bbm_driver_nch.sv
// Scoreboard bench for bbm_driver_nch (NCH=2, INV_MASK=2'b10, default build without filter).
module tb_bbm_driver_nch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] en = '0;
  logic [1:0] i = '0;
  logic [5:0] dt = '0;
  logic       fault = 1'b0;
  logic       fault_clr = 1'b0;
  logic [1:0] hs, ls;
  logic       fault_lat;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [1:0] hs;
    logic [1:0] ls;
    logic       fl;
    string      name;
  } exp_t;

  exp_t q[$];

  bbm_driver_nch #(
    .NCH      (2),
    .DTW      (6),
    .INV_MASK (2'b10),
    .FILT     (2)
  ) dut (
    .CELCLK    (clk),
    .CELRST    (rst),
    .en        (en),
    .i         (i),
    .dt        (dt),
    .fault     (fault),
    .fault_clr (fault_clr),
    .hs        (hs),
    .ls        (ls),
    .fault_lat (fault_lat)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic r, input logic [1:0] e, input logic [1:0] ii,
                      input logic [5:0] d, input logic f, input logic fc,
                      input logic [1:0] ehs, input logic [1:0] els, input logic efl,
                      input string nm);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; i = ii; dt = d; fault = f; fault_clr = fc;
    x.hs = ehs; x.ls = els; x.fl = efl; x.name = nm;
    q.push_back(x);
  endtask

  // Monitor: every registered output cycle pops one expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        checks++;
        if ({hs, ls, fault_lat} !== {x.hs, x.ls, x.fl}) begin
          fails++;
          $display("FAIL %s: got hs=%b ls=%b fl=%b, want hs=%b ls=%b fl=%b",
                   x.name, hs, ls, fault_lat, x.hs, x.ls, x.fl);
        end else begin
          $display("ok   %s: hs=%b ls=%b fl=%b", x.name, hs, ls, fault_lat);
        end
        checks++;
        if ((hs & ls) !== 2'b00) begin
          fails++;
          $display("FAIL overlap_%s: hs&ls=%b want 00", x.name, hs & ls);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // reset
    step(1, 2'b00, 2'b00, 6'd3, 0, 0, 2'b00, 2'b00, 0, "reset0");
    step(1, 2'b00, 2'b00, 6'd3, 0, 0, 2'b00, 2'b00, 0, "reset1");
    // ch0 enable, dt=3, c=1: four both-low cycles then HS
    for (int k = 0; k < 4; k++)
      step(0, 2'b01, 2'b01, 6'd3, 0, 0, 2'b00, 2'b00, 0, "t1_dead");
    step(0, 2'b01, 2'b01, 6'd3, 0, 0, 2'b01, 2'b00, 0, "t1_hs_on");
    step(0, 2'b01, 2'b01, 6'd3, 0, 0, 2'b01, 2'b00, 0, "t1_hold");
    // toggle to 0 at dt=5: six both-low cycles then LS
    for (int k = 0; k < 6; k++)
      step(0, 2'b01, 2'b00, 6'd5, 0, 0, 2'b00, 2'b00, 0, "t2_dead");
    step(0, 2'b01, 2'b00, 6'd5, 0, 0, 2'b00, 2'b01, 0, "t2_ls_on");
    // reversal mid-DEAD at dt=4, dt changed mid-DEAD: five both-low, exit to LS
    step(0, 2'b01, 2'b01, 6'd4, 0, 0, 2'b00, 2'b00, 0, "t5_dead");
    step(0, 2'b01, 2'b01, 6'd4, 0, 0, 2'b00, 2'b00, 0, "t5_dead");
    step(0, 2'b01, 2'b00, 6'd1, 0, 0, 2'b00, 2'b00, 0, "t5_rev");
    step(0, 2'b01, 2'b00, 6'd1, 0, 0, 2'b00, 2'b00, 0, "t5_rev");
    step(0, 2'b01, 2'b00, 6'd1, 0, 0, 2'b00, 2'b00, 0, "t5_rev");
    step(0, 2'b01, 2'b00, 6'd1, 0, 0, 2'b00, 2'b01, 0, "t5_ls_on");
    // fault during DEAD, clear arbitration, re-entry through DEAD
    step(0, 2'b01, 2'b01, 6'd3, 0, 0, 2'b00, 2'b00, 0, "t4_dead");
    step(0, 2'b01, 2'b01, 6'd3, 1, 0, 2'b00, 2'b00, 1, "t4_fault");
    step(0, 2'b01, 2'b01, 6'd3, 0, 0, 2'b00, 2'b00, 1, "t4_latched");
    step(0, 2'b01, 2'b01, 6'd3, 1, 1, 2'b00, 2'b00, 1, "t4_fault_wins");
    step(0, 2'b01, 2'b01, 6'd3, 0, 1, 2'b00, 2'b00, 0, "t4_clear");
    for (int k = 0; k < 4; k++)
      step(0, 2'b01, 2'b01, 6'd3, 0, 0, 2'b00, 2'b00, 0, "t4_reenter");
    step(0, 2'b01, 2'b01, 6'd3, 0, 0, 2'b01, 2'b00, 0, "t4_hs_on");
    // two channels, ch1 inverted: i=11 gives ch0 HS, ch1 LS
    step(0, 2'b11, 2'b11, 6'd0, 0, 0, 2'b01, 2'b00, 0, "t3_ch1_dead");
    step(0, 2'b11, 2'b11, 6'd0, 0, 0, 2'b01, 2'b10, 0, "t3_both");
    // dt=0 still gives one both-low cycle on ch0
    step(0, 2'b11, 2'b10, 6'd0, 0, 0, 2'b00, 2'b10, 0, "t3_dt0_dead");
    step(0, 2'b11, 2'b10, 6'd0, 0, 0, 2'b00, 2'b11, 0, "t3_dt0_ls");
    // enable drop mid-DEAD on ch0, then re-entry
    step(0, 2'b11, 2'b11, 6'd3, 0, 0, 2'b00, 2'b10, 0, "t6_dead");
    step(0, 2'b10, 2'b11, 6'd3, 0, 0, 2'b00, 2'b10, 0, "t6_en_off");
    step(0, 2'b11, 2'b11, 6'd0, 0, 0, 2'b00, 2'b10, 0, "t6_redead");
    step(0, 2'b11, 2'b11, 6'd0, 0, 0, 2'b01, 2'b10, 0, "t6_reenter");
    // fault, then reset overrides and clears the latch
    step(0, 2'b11, 2'b11, 6'd0, 1, 0, 2'b00, 2'b00, 1, "t7_fault");
    step(1, 2'b11, 2'b11, 6'd0, 0, 0, 2'b00, 2'b00, 0, "t7_reset");
    step(0, 2'b11, 2'b11, 6'd0, 0, 0, 2'b00, 2'b00, 0, "t7_dead");
    step(0, 2'b11, 2'b11, 6'd0, 0, 0, 2'b01, 2'b10, 0, "t7_restart");

    for (int k = 0; k < 20 && q.size() > 0; k++)
      @(posedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
